// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the team ALU. One operation is in
// flight at a time (IDLE -> EXEC -> RESP), and a saturating counter tracks completions.

module alu (
  input  logic [1:0]  control,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  output logic [31:0] result,
  output logic        overflow,
  output logic        carry,
  output logic        negative,
  output logic        zero
);

  logic        sub;
  logic [31:0] b_eff;
  logic [32:0] sum;

  // SUB is a + ~b + 1, so carry is the no-borrow indication.
  always_comb begin
    sub      = (control == 2'b01);
    b_eff    = sub ? ~input_b : input_b;
    sum      = {1'b0, input_a} + {1'b0, b_eff} + {32'd0, sub};
    result   = '0;
    overflow = 1'b0;
    carry    = 1'b0;
    case (control)
      2'b00, 2'b01: begin
        result   = sum[31:0];
        carry    = sum[32];
        overflow = (input_a[31] == b_eff[31]) && (sum[31] != input_a[31]);
      end
      2'b10:   result = input_a & input_b;
      default: result = input_a | input_b;
    endcase
    negative = result[31];
    zero     = (result == 32'd0);
  end

endmodule

module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_control0,
  input  logic [1:0]  req_control1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_source,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_carry,
  output logic        rsp_negative,
  output logic        rsp_zero,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic        prio;
  logic        src;
  logic [1:0]  lat_control;
  logic [31:0] lat_a;
  logic [31:0] lat_b;
  logic        grant_any;
  logic        grant_idx;
  logic        accept;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        alu_carry;
  logic        alu_negative;
  logic        alu_zero;

  alu u_alu (
    .control  (lat_control),
    .input_a  (lat_a),
    .input_b  (lat_b),
    .result   (alu_result),
    .overflow (alu_overflow),
    .carry    (alu_carry),
    .negative (alu_negative),
    .zero     (alu_zero)
  );

  // Priority holder wins; the other requester is served only when it is alone.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = prio;
    if (req_valid[prio]) begin
      grant_any = 1'b1;
      grant_idx = prio;
    end else if (req_valid[~prio]) begin
      grant_any = 1'b1;
      grant_idx = ~prio;
    end
    req_ready = 2'b00;
    if ((state == IDLE) && rst_n && grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign accept     = |(req_valid & req_ready);
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);
  assign rsp_source = src;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      prio         <= 1'b0;
      src          <= 1'b0;
      lat_control  <= 2'b00;
      lat_a        <= '0;
      lat_b        <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_negative <= 1'b0;
      rsp_zero     <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            src         <= grant_idx;
            lat_control <= grant_idx ? req_control1 : req_control0;
            lat_a       <= grant_idx ? req_a1 : req_a0;
            lat_b       <= grant_idx ? req_b1 : req_b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_result   <= alu_result;
          rsp_overflow <= alu_overflow;
          rsp_carry    <= alu_carry;
          rsp_negative <= alu_negative;
          rsp_zero     <= alu_zero;
          state        <= RESP;
        end
        RESP: begin
          // Handing priority to the other requester is what prevents starvation.
          if (rsp_ready) begin
            state <= IDLE;
            prio  <= ~src;
            if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
